// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for one shared 64 KiB memory port
// Optional fetch anti-starvation guard: define ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter int unsigned ACCESS_LAT = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_gnt,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic [3:0]  dm_we,
  input  logic [15:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_gnt,
  output logic        dm_ack,
  output logic [31:0] dm_rdata,
  output logic [3:0]  mem_w_en,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [15:0] addr_q;
  logic [3:0]  we_q;
  logic [31:0] wdata_q;
  logic        owner_q;
  logic        if_ack_q;
  logic        dm_ack_q;
  logic [31:0] if_rdata_q;
  logic [31:0] dm_rdata_q;
  logic        fetch_first;
  logic        last_cycle;

`ifdef ARB_STARVE_GUARD_EN
  logic [3:0] starve_q;

  assign fetch_first = (32'(starve_q) >= STARVE_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
    end else if (if_gnt || (state_q == IDLE && !if_req)) begin
      starve_q <= '0;
    end else if (dm_gnt && if_req && starve_q != 4'hF) begin
      starve_q <= starve_q + 4'd1;
    end
  end
`else
  assign fetch_first = 1'b0;
`endif

  always_comb begin
    dm_gnt = 1'b0;
    if_gnt = 1'b0;
    if (!rst && state_q == IDLE) begin
      dm_gnt = dm_req && !(if_req && fetch_first);
      if_gnt = if_req && !dm_gnt;
    end
  end

  // Write enables only in the final BUSY cycle so a store commits exactly once.
  assign last_cycle = (state_q == BUSY) && (cnt_q == 4'd1);
  assign mem_w_en   = (last_cycle && !rst) ? we_q : 4'h0;
  assign mem_addr   = (state_q == BUSY) ? addr_q : 16'h0;
  assign mem_wdata  = (state_q == BUSY) ? wdata_q : 32'h0;

  assign if_ack   = if_ack_q;
  assign dm_ack   = dm_ack_q;
  assign if_rdata = if_rdata_q;
  assign dm_rdata = dm_rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      we_q       <= '0;
      wdata_q    <= '0;
      owner_q    <= 1'b0;
      if_ack_q   <= 1'b0;
      dm_ack_q   <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      if_ack_q <= 1'b0;
      dm_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (dm_gnt) begin
            addr_q  <= dm_addr;
            we_q    <= dm_we;
            wdata_q <= dm_wdata;
            owner_q <= 1'b1;
            cnt_q   <= 4'(ACCESS_LAT);
            state_q <= BUSY;
          end else if (if_gnt) begin
            addr_q  <= {if_addr[15:2], 2'b00};
            we_q    <= 4'h0;
            wdata_q <= 32'h0;
            owner_q <= 1'b0;
            cnt_q   <= 4'(ACCESS_LAT);
            state_q <= BUSY;
          end
        end
        BUSY: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            if (owner_q) begin
              dm_rdata_q <= mem_rdata;
              dm_ack_q   <= 1'b1;
            end else begin
              if_rdata_q <= mem_rdata;
              if_ack_q   <= 1'b1;
            end
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized and directed bench for mem_port_arbiter (latencies 1 and 3)
module tb_mem_port_arbiter;

  localparam int LAT0 = 1;
  localparam int LAT1 = 3;
  localparam int STARVE = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req [2];
  logic [15:0] if_addr [2];
  logic        if_gnt [2];
  logic        if_ack [2];
  logic [31:0] if_rdata [2];
  logic        dm_req [2];
  logic [3:0]  dm_we [2];
  logic [15:0] dm_addr [2];
  logic [31:0] dm_wdata [2];
  logic        dm_gnt [2];
  logic        dm_ack [2];
  logic [31:0] dm_rdata [2];
  logic [3:0]  mem_w_en [2];
  logic [15:0] mem_addr [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];

  logic [31:0] mem [2][16384];
  logic [31:0] mmem [2][16384];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ACCESS_LAT(LAT0), .STARVE_MAX(STARVE)) u_dut0 (
    .clk(clk), .rst(rst),
    .if_req(if_req[0]), .if_addr(if_addr[0]), .if_gnt(if_gnt[0]), .if_ack(if_ack[0]), .if_rdata(if_rdata[0]),
    .dm_req(dm_req[0]), .dm_we(dm_we[0]), .dm_addr(dm_addr[0]), .dm_wdata(dm_wdata[0]),
    .dm_gnt(dm_gnt[0]), .dm_ack(dm_ack[0]), .dm_rdata(dm_rdata[0]),
    .mem_w_en(mem_w_en[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
  );

  mem_port_arbiter #(.ACCESS_LAT(LAT1), .STARVE_MAX(STARVE)) u_dut1 (
    .clk(clk), .rst(rst),
    .if_req(if_req[1]), .if_addr(if_addr[1]), .if_gnt(if_gnt[1]), .if_ack(if_ack[1]), .if_rdata(if_rdata[1]),
    .dm_req(dm_req[1]), .dm_we(dm_we[1]), .dm_addr(dm_addr[1]), .dm_wdata(dm_wdata[1]),
    .dm_gnt(dm_gnt[1]), .dm_ack(dm_ack[1]), .dm_rdata(dm_rdata[1]),
    .mem_w_en(mem_w_en[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
  );

  assign mem_rdata[0] = mem[0][mem_addr[0][15:2]];
  assign mem_rdata[1] = mem[1][mem_addr[1][15:2]];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++)
      for (int b = 0; b < 4; b++)
        if (mem_w_en[k][b]) mem[k][mem_addr[k][15:2]][8*b +: 8] <= mem_wdata[k][8*b +: 8];
  end

  // Reference model: each access is a scheduled transaction (grant cycle g,
  // BUSY g+1..g+lat, commit at g+lat, ack at g+lat+1) against a shadow memory.
  int          cyc = 0;
  bit          act [2];
  int          g_cyc [2];
  bit          t_own [2];
  logic [15:0] t_addr [2];
  logic [3:0]  t_we [2];
  logic [31:0] t_wd [2];
  bit          ackp [2];
  int          ack_cyc [2];
  bit          ack_own [2];
  logic [31:0] e_if_rd [2];
  logic [31:0] e_dm_rd [2];
  bit          dm_rd_ok [2];
  bit          e_if_gnt [2];
  bit          e_dm_gnt [2];
  bit          e_if_ack [2];
  bit          e_dm_ack [2];
  int          starve [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int lat(input int k);
    return (k == 0) ? LAT0 : LAT1;
  endfunction

  task automatic check_k(input int k);
    bit busy, commit, gi, gd, ai, ad;
    logic [31:0] word;
    string p;
    p = $sformatf("u%0d_", k);
    busy   = act[k] && cyc > g_cyc[k] && cyc <= g_cyc[k] + lat(k);
    commit = act[k] && cyc == g_cyc[k] + lat(k);
    gi = 1'b0;
    gd = 1'b0;
    if (!rst && !busy) begin
      gd = dm_req[k];
`ifdef ARB_STARVE_GUARD_EN
      if (if_req[k] && starve[k] >= STARVE) gd = 1'b0;
`endif
      gi = if_req[k] && !gd;
    end
    ai = ackp[k] && ack_cyc[k] == cyc && !ack_own[k];
    ad = ackp[k] && ack_cyc[k] == cyc && ack_own[k];
    e_if_gnt[k] = gi;
    e_dm_gnt[k] = gd;
    e_if_ack[k] = ai;
    e_dm_ack[k] = ad;
    chk({p, "if_gnt"}, 32'(if_gnt[k]), 32'(gi));
    chk({p, "dm_gnt"}, 32'(dm_gnt[k]), 32'(gd));
    chk({p, "if_ack"}, 32'(if_ack[k]), 32'(ai));
    chk({p, "dm_ack"}, 32'(dm_ack[k]), 32'(ad));
    chk({p, "if_rdata"}, if_rdata[k], e_if_rd[k]);
    if (dm_rd_ok[k]) chk({p, "dm_rdata"}, dm_rdata[k], e_dm_rd[k]);
    chk({p, "mem_addr"}, 32'(mem_addr[k]), busy ? 32'(t_addr[k]) : 32'h0);
    chk({p, "mem_wdata"}, mem_wdata[k], busy ? t_wd[k] : 32'h0);
    chk({p, "mem_w_en"}, 32'(mem_w_en[k]), (commit && !rst) ? 32'(t_we[k]) : 32'h0);

    if (rst) begin
      act[k] = 1'b0;
      ackp[k] = 1'b0;
      e_if_rd[k] = '0;
      e_dm_rd[k] = '0;
      dm_rd_ok[k] = 1'b1;
      starve[k] = 0;
    end else begin
      if (commit) begin
        word = mmem[k][t_addr[k][15:2]];
        if (t_own[k]) begin
          e_dm_rd[k] = word;
          dm_rd_ok[k] = (t_we[k] == 4'h0);
        end else begin
          e_if_rd[k] = word;
        end
        for (int b = 0; b < 4; b++)
          if (t_we[k][b]) mmem[k][t_addr[k][15:2]][8*b +: 8] = t_wd[k][8*b +: 8];
        ackp[k] = 1'b1;
        ack_cyc[k] = cyc + 1;
        ack_own[k] = t_own[k];
        act[k] = 1'b0;
      end
      if (gi || gd) begin
        act[k] = 1'b1;
        g_cyc[k] = cyc;
        t_own[k] = gd;
        t_addr[k] = gd ? dm_addr[k] : {if_addr[k][15:2], 2'b00};
        t_we[k] = gd ? dm_we[k] : 4'h0;
        t_wd[k] = gd ? dm_wdata[k] : 32'h0;
      end
      if (gi || (!busy && !if_req[k])) starve[k] = 0;
      else if (gd && if_req[k] && starve[k] < 15) starve[k]++;
    end
  endtask

  task automatic tick_check();
    @(negedge clk);
    check_k(0);
    check_k(1);
  endtask

  task automatic tick_edge();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      tick_check();
      tick_edge();
    end
  endtask

  // One access on instance k: hold req until granted, then wait for the ack.
  task automatic do_access(input int k, input bit is_dm, input logic [3:0] we, input logic [15:0] addr,
                           input logic [31:0] wd, output int ack_lat, output int wcycles, output logic [31:0] rd);
    int n;
    bit got;
    ack_lat = 0;
    wcycles = 0;
    rd = '0;
    got = 1'b0;
    if (is_dm) begin
      dm_req[k] = 1'b1; dm_we[k] = we; dm_addr[k] = addr; dm_wdata[k] = wd;
    end else begin
      if_req[k] = 1'b1; if_addr[k] = addr;
    end
    for (n = 0; n < 50 && !got; n++) begin
      tick_check();
      got = is_dm ? e_dm_gnt[k] : e_if_gnt[k];
      tick_edge();
    end
    if_req[k] = 1'b0;
    dm_req[k] = 1'b0;
    if (!got) begin
      chk("grant_timeout", 32'h0, 32'h1);
      return;
    end
    got = 1'b0;
    for (n = 1; n < 50 && !got; n++) begin
      tick_check();
      if (mem_w_en[k] != 4'h0) wcycles++;
      got = is_dm ? e_dm_ack[k] : e_if_ack[k];
      if (got) begin
        ack_lat = n;
        rd = is_dm ? dm_rdata[k] : if_rdata[k];
      end
      tick_edge();
    end
    if (!got) chk("ack_timeout", 32'h0, 32'h1);
  endtask

  task automatic drive_rand(input int k);
    if (if_req[k] && e_if_gnt[k]) begin
      if_req[k] = 1'b0;
      if_addr[k] = 16'($urandom);
    end else if (if_req[k] && $urandom_range(0, 19) == 0) begin
      if_req[k] = 1'b0;
    end else if (!if_req[k] && $urandom_range(0, 2) == 0) begin
      if_req[k] = 1'b1;
      if_addr[k] = 16'h0100 | 16'($urandom_range(0, 255));
    end
    if (dm_req[k] && e_dm_gnt[k]) begin
      dm_req[k] = 1'b0;
      dm_wdata[k] = $urandom;
    end else if (dm_req[k] && $urandom_range(0, 19) == 0) begin
      dm_req[k] = 1'b0;
    end else if (!dm_req[k] && $urandom_range(0, 2) == 0) begin
      dm_req[k] = 1'b1;
      dm_we[k] = $urandom_range(0, 1) ? 4'($urandom_range(0, 15)) : 4'h0;
      dm_addr[k] = 16'h0100 | 16'($urandom_range(0, 255));
      dm_wdata[k] = $urandom;
    end
  endtask

  initial begin
    int lt, wc, n_if, n_gr, first_if;
    logic [31:0] rd, saved;

    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16384; i++) begin
        mem[k][i] <= (i * 32'h9E3779B1) ^ 32'(k);
        mmem[k][i] = (i * 32'h9E3779B1) ^ 32'(k);
      end
      mem[k][4] <= 32'h00500513;
      mmem[k][4] = 32'h00500513;
      if_req[k] = 0; if_addr[k] = 0; dm_req[k] = 0; dm_we[k] = 0; dm_addr[k] = 0; dm_wdata[k] = 0;
      act[k] = 0; ackp[k] = 0; e_if_rd[k] = 0; e_dm_rd[k] = 0; dm_rd_ok[k] = 1; starve[k] = 0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tick_check();
    tick_edge();
    rst = 1'b0;
    idle_cycles(2);

    // Fetch alone, latency 1: gnt T, mem_addr word-aligned at T+1, ack T+2.
    if_req[0] = 1'b1; if_addr[0] = 16'h0012;
    tick_check(); chk("t1_if_gnt", 32'(if_gnt[0]), 32'h1); tick_edge();
    if_req[0] = 1'b0;
    tick_check(); chk("t1_mem_addr", 32'(mem_addr[0]), 32'h0010); tick_edge();
    tick_check(); chk("t1_if_ack", 32'(if_ack[0]), 32'h1); chk("t1_if_rdata", if_rdata[0], 32'h00500513); tick_edge();

    // Store, load back, byte store, load back.
    do_access(0, 1, 4'hF, 16'h0100, 32'hDEADBEEF, lt, wc, rd);
    chk("t2_store_wcycles", 32'(wc), 32'd1);
    chk("t2_store_acklat", 32'(lt), 32'd2);
    do_access(0, 1, 4'h0, 16'h0100, 32'h0, lt, wc, rd);
    chk("t2_load_data", rd, 32'hDEADBEEF);
    do_access(0, 1, 4'b0010, 16'h0100, 32'h0000AA00, lt, wc, rd);
    do_access(0, 1, 4'h0, 16'h0100, 32'h0, lt, wc, rd);
    chk("t2_byte_merge", rd, 32'hDEADAAEF);
    idle_cycles(2);

    // Simultaneous requests: data first, fetch granted in the dm_ack cycle.
    saved = if_rdata[0];
    if_req[0] = 1'b1; if_addr[0] = 16'h0010;
    dm_req[0] = 1'b1; dm_we[0] = 4'h0; dm_addr[0] = 16'h0100;
    tick_check(); chk("t3_dm_first", 32'(dm_gnt[0]), 32'h1); chk("t3_if_wait", 32'(if_gnt[0]), 32'h0); tick_edge();
    dm_req[0] = 1'b0;
    tick_check(); tick_edge();
    tick_check(); chk("t3_dm_ack", 32'(dm_ack[0]), 32'h1); chk("t3_if_gnt", 32'(if_gnt[0]), 32'h1);
    chk("t3_if_rdata_kept", if_rdata[0], saved); tick_edge();
    if_req[0] = 1'b0;
    tick_check(); tick_edge();
    tick_check(); chk("t3_if_ack", 32'(if_ack[0]), 32'h1); tick_edge();
    idle_cycles(2);

    // Latency 3: single write cycle, ack at T+4, no grants while BUSY.
    do_access(1, 1, 4'hF, 16'h0140, 32'h0BADF00D, lt, wc, rd);
    chk("t4_wcycles", 32'(wc), 32'd1);
    chk("t4_acklat", 32'(lt), 32'd4);
    dm_req[1] = 1'b1; dm_we[1] = 4'h0; dm_addr[1] = 16'h0140;
    tick_check(); chk("t4_dm_gnt", 32'(dm_gnt[1]), 32'h1); tick_edge();
    dm_req[1] = 1'b0; if_req[1] = 1'b1; if_addr[1] = 16'h0144;
    for (int i = 0; i < 3; i++) begin
      tick_check(); chk("t4_busy_no_gnt", 32'(if_gnt[1]), 32'h0); tick_edge();
    end
    tick_check(); chk("t4_load", dm_rdata[1], 32'h0BADF00D); chk("t4_if_gnt_after", 32'(if_gnt[1]), 32'h1); tick_edge();
    if_req[1] = 1'b0;
    idle_cycles(5);

    // Reset in the commit cycle of a store drops it entirely.
    saved = mem[1][16'h0200 >> 2];
    dm_req[1] = 1'b1; dm_we[1] = 4'hF; dm_addr[1] = 16'h0200; dm_wdata[1] = 32'h12345678;
    tick_check(); chk("t5_gnt", 32'(dm_gnt[1]), 32'h1); tick_edge();
    dm_req[1] = 1'b0;
    idle_cycles(2);
    rst = 1'b1;
    tick_check(); chk("t5_w_en_blocked", 32'(mem_w_en[1]), 32'h0); tick_edge();
    rst = 1'b0;
    tick_check();
    chk("t5_no_ack", 32'(dm_ack[1]), 32'h0);
    chk("t5_mem_kept", mem[1][16'h0200 >> 2], saved);
    chk("t5_dm_rdata_zero", dm_rdata[1], 32'h0);
    chk("t5_mem_addr_idle", 32'(mem_addr[1]), 32'h0);
    tick_edge();
    idle_cycles(2);

    // Both requesters held continuously on the latency-1 instance.
    n_if = 0; n_gr = 0; first_if = -1;
    if_req[0] = 1'b1; if_addr[0] = 16'h0010;
    dm_req[0] = 1'b1; dm_we[0] = 4'h0; dm_addr[0] = 16'h0104;
    for (int i = 0; i < 200 && n_gr < 20; i++) begin
      tick_check();
      if (e_if_gnt[0]) begin
        if (first_if < 0) first_if = n_gr;
        n_if++;
      end
      if (e_if_gnt[0] || e_dm_gnt[0]) n_gr++;
      tick_edge();
    end
    if_req[0] = 1'b0; dm_req[0] = 1'b0;
    chk("t6_grants", 32'(n_gr), 32'd20);
`ifdef ARB_STARVE_GUARD_EN
    chk("t6_first_if", 32'(first_if), 32'(STARVE));
    chk("t6_if_count", 32'(n_if), 32'd4);
`else
    chk("t6_if_starved", 32'(n_if), 32'd0);
`endif
    idle_cycles(4);

    for (int i = 0; i < 2000; i++) begin
      tick_check();
      tick_edge();
      rst = ($urandom_range(0, 199) == 0);
      drive_rand(0);
      drive_rand(1);
    end
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if_req[k] = 1'b0;
      dm_req[k] = 1'b0;
    end
    idle_cycles(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
